// File: rtl/mul_share_arbiter_pkg.sv
// rtl/mul_share_arbiter_pkg.sv - shared types, defaults and helpers for the shared multiplier arbiter
//
// Purpose: state encoding for the arbiter FSM, default operand width and a
//          constant-evaluable clog2 used to size ids and counters.
// Ports:   none (package).

package mul_share_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2, returning at least 1 so it can size a vector directly.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_signed_mul.sv
// rtl/seq_signed_mul.sv - iterative sign-magnitude shift-add multiplier, one step per clock
//
// Purpose: latches a and b on start, then runs WIDTH shift-add steps over the
//          bits of |b|. done is high during the final step; product is valid
//          (combinationally, including that final step) while done is high.
// Ports:
//   CLK      in   clock, rising edge
//   reset    in   asynchronous active-high reset
//   start    in   load operands and begin a new product
//   a, b     in   WIDTH-bit signed operands
//   done     out  high on the cycle whose rising edge completes the product
//   product  out  2*WIDTH-bit signed product, meaningful while done is high

module seq_signed_mul
    import mul_share_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = clog2(WIDTH);
    localparam logic [WIDTH:0]     ONE_M = 1;
    localparam logic [2*WIDTH-1:0] ONE_P = 1;
    localparam logic [CW-1:0]      LAST  = CW'(WIDTH - 1);

    // Magnitudes are one bit wider than the operands so -2^(WIDTH-1) fits.
    logic [WIDTH:0]     a_ext;
    logic [WIDTH:0]     b_ext;
    logic [WIDTH:0]     a_mag;
    logic [WIDTH:0]     b_mag;

    logic [2*WIDTH-1:0] ma;
    logic [WIDTH:0]     mb;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [CW-1:0]      cnt;
    logic               running;
    logic               neg;

    assign a_ext = {a[WIDTH-1], a};
    assign b_ext = {b[WIDTH-1], b};
    assign a_mag = a[WIDTH-1] ? (~a_ext + ONE_M) : a_ext;
    assign b_mag = b[WIDTH-1] ? (~b_ext + ONE_M) : b_ext;

    assign acc_next = acc + (mb[0] ? ma : '0);
    assign done     = running && (cnt == LAST);

    // A zero magnitude stays zero regardless of the sign combination.
    assign product  = (neg && (acc_next != '0)) ? (~acc_next + ONE_P) : acc_next;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            ma      <= '0;
            mb      <= '0;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b0;
            neg     <= 1'b0;
        end else if (start) begin
            ma      <= {{(WIDTH-1){1'b0}}, a_mag};
            mb      <= b_mag;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b1;
            neg     <= a[WIDTH-1] ^ b[WIDTH-1];
        end else if (running) begin
            acc <= acc_next;
            ma  <= ma << 1;
            mb  <= mb >> 1;
            cnt <= cnt + CW'(1);
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin arbiter sharing one sequential signed multiplier
//
// Purpose: picks one pending requester in round-robin order, latches its
//          operands into the shared multiplier and returns the tagged product.
// Ports:
//   CLK        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   req        in   per-requester request levels
//   in_a/in_b  in   packed signed operands, slice i belongs to requester i
//   gnt        out  one-hot one-cycle acceptance pulse
//   out        out  signed product, held until the next result
//   out_valid  out  one-cycle pulse marking a new product
//   out_id     out  requester owning out
//   busy       out  high whenever the FSM is not idle

module mul_share_arbiter
    import mul_share_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ID_W  = clog2(N_REQ)
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   in_a,
    input  logic [N_REQ*WIDTH-1:0]   in_b,
    output logic [N_REQ-1:0]         gnt,
    output logic [2*WIDTH-1:0]       out,
    output logic                     out_valid,
    output logic [ID_W-1:0]          out_id,
    output logic                     busy
);

    state_t             state_q;
    state_t             state_d;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    pick_id;
    logic               found;
    logic               start;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    // Search upward from the slot after the last winner, wrapping at N_REQ.
    always_comb begin
        found   = 1'b0;
        pick_id = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!found && req[idx]) begin
                found   = 1'b1;
                pick_id = ID_W'(idx);
            end
        end
    end

    assign a_sel = in_a[int'(pick_id)*WIDTH +: WIDTH];
    assign b_sel = in_b[int'(pick_id)*WIDTH +: WIDTH];

    seq_signed_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .CLK     (CLK),
        .reset   (reset),
        .start   (start),
        .a       (a_sel),
        .b       (b_sel),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    start   = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            gnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            ptr_q     <= ID_W'(N_REQ - 1);
            id_q      <= '0;
        end else begin
            gnt       <= '0;
            out_valid <= 1'b0;
            if (start) begin
                gnt   <= N_REQ'(1) << pick_id;
                ptr_q <= pick_id;
                id_q  <= pick_id;
            end
            if ((state_q == ST_BUSY) && mul_done) begin
                out       <= mul_product;
                out_id    <= id_q;
                out_valid <= 1'b1;
            end
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule
